// File: rtl/micro1_pkg.sv
// -----------------------------------------------------------------------------
// micro1_pkg
// Shared MICRO-1 datapath definitions: data widths and the selector/operation
// enums carried on control_interface. Every enum uses encoding 0 as its
// no-operation value so that an all-zero control word is a safe NOP.
// -----------------------------------------------------------------------------
package micro1_pkg;

    localparam int DATA_WIDTH       = 16;
    localparam int FLAG_WIDTH       = 4;
    localparam int RBUS_LOWER_WIDTH = 8;

    typedef enum logic [2:0] {
        LBUS_NOP     = 3'd0,
        LBUS_GPR     = 3'd1,
        LBUS_PC      = 3'd2,
        LBUS_MDR     = 3'd3,
        LBUS_LITERAL = 3'd4,
        LBUS_FSR     = 3'd5
    } LBUS_SELECT;

    typedef enum logic [2:0] {
        RBUS_NOP     = 3'd0,
        RBUS_GPR     = 3'd1,
        RBUS_LITERAL = 3'd2,
        RBUS_MDR     = 3'd3,
        RBUS_INBUS   = 3'd4
    } RBUS_SELECT;

    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_PASS_L = 4'd6,
        ALU_PASS_R = 4'd7,
        ALU_INC    = 4'd8
    } ALU_OPERATION;

    typedef enum logic [2:0] {
        SHIFT_NOP = 3'd0,
        SHIFT_LSL = 3'd1,
        SHIFT_LSR = 3'd2,
        SHIFT_ASR = 3'd3,
        SHIFT_ROL = 3'd4,
        SHIFT_ROR = 3'd5
    } SHIFTER_OPERATION;

    typedef enum logic [2:0] {
        GPR_NOP     = 3'd0,
        GPR_R_FIELD = 3'd1,
        GPR_S_FIELD = 3'd2,
        GPR_FIXED   = 3'd3
    } GPR_DESTINATION;

    typedef enum logic [1:0] {
        IR_NOP   = 2'd0,
        IR_INBUS = 2'd1,
        IR_SBUS  = 2'd2
    } IR_SOURCE;

endpackage

// File: rtl/micro1_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// package_micro_sequencer
// Microinstruction format and sequencer enums for micro1_sequencer.
// MICROINSTRUCTION is the raw control-store word; its datapath fields reuse
// the micro1_pkg enums so the word maps field-for-field onto control_interface.
// -----------------------------------------------------------------------------
package package_micro_sequencer;

    import micro1_pkg::*;

    localparam int MICRO_CS_ADDR_WIDTH = 10;

    // Codes 6 and 7 are unassigned and behave as NEXT.
    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_BRANCH   = 3'd2,
        SEQ_DISPATCH = 3'd3,
        SEQ_WAITMEM  = 3'd4,
        SEQ_HALT     = 3'd5
    } SEQ_OPERATION;

    typedef enum logic [2:0] {
        COND_ALU_COUT      = 3'd0,
        COND_SHIFTER_COUT  = 3'd1,
        COND_LBUS_MSB      = 3'd2,
        COND_RBUS_MSB      = 3'd3,
        COND_SBUS_MSB      = 3'd4,
        COND_ABUS_ZERO     = 3'd5,
        COND_RBUS_LOW_ZERO = 3'd6,
        COND_ALWAYS        = 3'd7
    } CONDITION_SELECT;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } SEQ_STATE;

    typedef struct packed {
        LBUS_SELECT                     lbus_sel;
        RBUS_SELECT                     rbus_sel;
        ALU_OPERATION                   alu_op;
        SHIFTER_OPERATION               shifter_op;
        GPR_DESTINATION                 gpr_dest;
        IR_SOURCE                       ir_src;
        logic                           set_mar;
        logic                           set_fsr;
        logic                           set_pc;
        logic [DATA_WIDTH-1:0]          literal;
        logic [FLAG_WIDTH-1:0]          flags;
        logic                           cin;
        logic                           mem_read;
        SEQ_OPERATION                   seq_op;
        CONDITION_SELECT                cond_sel;
        logic                           cond_invert;
        logic [MICRO_CS_ADDR_WIDTH-1:0] target;
    } MICROINSTRUCTION;

endpackage

// File: rtl/control_interface.sv
// -----------------------------------------------------------------------------
// control_interface
// Control and status bundle between the microprogram sequencer (controler)
// and the MICRO-1 datapath (datapath).
//   controler drives: bus/ALU/shifter/GPR/IR selectors, set_mar, set_fsr,
//                     set_pc, literal, flags, cin, inbus_valid
//   datapath drives:  alu_cout, shifter_cout, lbus/rbus/sbus MSBs, abus,
//                     rbus_lower, ir
// -----------------------------------------------------------------------------
interface control_interface;

    import micro1_pkg::*;

    LBUS_SELECT                   lbus_selector;
    RBUS_SELECT                   rbus_selector;
    ALU_OPERATION                 alu_operation;
    SHIFTER_OPERATION             shifter_operation;
    GPR_DESTINATION               gpr_destination_selector;
    IR_SOURCE                     ir_source_selector;
    logic                         set_mar;
    logic                         set_fsr;
    logic                         set_pc;
    logic [DATA_WIDTH-1:0]        literal;
    logic [FLAG_WIDTH-1:0]        flags;
    logic                         cin;
    logic                         inbus_valid;

    logic                         alu_cout;
    logic                         shifter_cout;
    logic                         lbus_msb;
    logic                         rbus_msb;
    logic                         sbus_msb;
    logic [DATA_WIDTH-1:0]        abus;
    logic [RBUS_LOWER_WIDTH-1:0]  rbus_lower;
    logic [DATA_WIDTH-1:0]        ir;

    modport controler (
        output lbus_selector, rbus_selector, alu_operation, shifter_operation,
               gpr_destination_selector, ir_source_selector,
               set_mar, set_fsr, set_pc, literal, flags, cin, inbus_valid,
        input  alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
               abus, rbus_lower, ir
    );

    modport datapath (
        input  lbus_selector, rbus_selector, alu_operation, shifter_operation,
               gpr_destination_selector, ir_source_selector,
               set_mar, set_fsr, set_pc, literal, flags, cin, inbus_valid,
        output alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
               abus, rbus_lower, ir
    );

endinterface

// File: rtl/micro1_condition_mux.sv
// -----------------------------------------------------------------------------
// micro1_condition_mux
// Combinational branch-condition select for the sequencer.
//   cond_sel      in   condition select
//   cond_invert   in   XORed onto the selected condition
//   alu_cout .. sbus_msb, abus, rbus_lower   in   datapath status
//   cond_true     out  final branch condition
// -----------------------------------------------------------------------------
module micro1_condition_mux
    import micro1_pkg::*, package_micro_sequencer::*;
(
    input  CONDITION_SELECT              cond_sel,
    input  logic                         cond_invert,
    input  logic                         alu_cout,
    input  logic                         shifter_cout,
    input  logic                         lbus_msb,
    input  logic                         rbus_msb,
    input  logic                         sbus_msb,
    input  logic [DATA_WIDTH-1:0]        abus,
    input  logic [RBUS_LOWER_WIDTH-1:0]  rbus_lower,
    output logic                         cond_true
);

    logic cond_raw;

    always_comb begin
        cond_raw = 1'b1;
        case (cond_sel)
            COND_ALU_COUT:      cond_raw = alu_cout;
            COND_SHIFTER_COUT:  cond_raw = shifter_cout;
            COND_LBUS_MSB:      cond_raw = lbus_msb;
            COND_RBUS_MSB:      cond_raw = rbus_msb;
            COND_SBUS_MSB:      cond_raw = sbus_msb;
            COND_ABUS_ZERO:     cond_raw = (abus == '0);
            COND_RBUS_LOW_ZERO: cond_raw = (rbus_lower == '0);
            default:            cond_raw = 1'b1;
        endcase
    end

    assign cond_true = cond_raw ^ cond_invert;

endmodule

// File: rtl/micro1_sequencer.sv
// -----------------------------------------------------------------------------
// micro1_sequencer
// Microprogram sequencer for the MICRO-1 core. The control-store ROM output
// (cs_data) is the microinstruction register; this block decodes it onto the
// controler side of control_interface and computes the next micro-address.
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   ctrl       controler modport of control_interface
//   cs_addr    out  control-store read address (= next micro-address)
//   cs_data    in   ROM word for the address presented last cycle
//   mem_ready  in   main-memory transfer complete
//   halted     out  sequencer has executed a HALT word
// -----------------------------------------------------------------------------
module micro1_sequencer
    import micro1_pkg::*, package_micro_sequencer::*;
#(
    parameter int CS_ADDR_WIDTH = MICRO_CS_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    control_interface.controler       ctrl,
    output logic [CS_ADDR_WIDTH-1:0]  cs_addr,
    input  MICROINSTRUCTION           cs_data,
    input  logic                      mem_ready,
    output logic                      halted
);

    SEQ_STATE                  state;
    MICROINSTRUCTION           uir;
    logic [CS_ADDR_WIDTH-1:0]  upc;
    logic [CS_ADDR_WIDTH-1:0]  upc_next;
    logic [CS_ADDR_WIDTH-1:0]  upc_inc;
    logic [CS_ADDR_WIDTH-1:0]  target_addr;
    logic [CS_ADDR_WIDTH-1:0]  dispatch_addr;
    logic                      running;
    logic                      mem_stall;
    logic                      cond_true;

    LBUS_SELECT                lbus_selector;
    RBUS_SELECT                rbus_selector;
    ALU_OPERATION              alu_operation;
    SHIFTER_OPERATION          shifter_operation;
    GPR_DESTINATION            gpr_destination_selector;
    IR_SOURCE                  ir_source_selector;
    logic                      set_mar;
    logic                      set_fsr;
    logic                      set_pc;
    logic [DATA_WIDTH-1:0]     literal;
    logic [FLAG_WIDTH-1:0]     flags;
    logic                      cin;
    logic                      inbus_valid;

    // The ROM output register doubles as the microinstruction register, so
    // upc always names the address of the word currently in uir.
    assign uir           = cs_data;
    assign running       = (state == ST_RUN);
    assign mem_stall     = running && (uir.seq_op == SEQ_WAITMEM) && !mem_ready;
    assign upc_inc       = upc + CS_ADDR_WIDTH'(1);
    assign target_addr   = CS_ADDR_WIDTH'(uir.target);
    assign dispatch_addr = {target_addr[CS_ADDR_WIDTH-1:8], ctrl.ir[DATA_WIDTH-1 -: 8]};
    assign cs_addr       = upc_next;

    micro1_condition_mux u_condition_mux (
        .cond_sel     (uir.cond_sel),
        .cond_invert  (uir.cond_invert),
        .alu_cout     (ctrl.alu_cout),
        .shifter_cout (ctrl.shifter_cout),
        .lbus_msb     (ctrl.lbus_msb),
        .rbus_msb     (ctrl.rbus_msb),
        .sbus_msb     (ctrl.sbus_msb),
        .abus         (ctrl.abus),
        .rbus_lower   (ctrl.rbus_lower),
        .cond_true    (cond_true)
    );

    // Next micro-address. A stalled WAITMEM or a HALT word re-presents upc so
    // the ROM keeps returning the same word.
    always_comb begin
        upc_next = upc;
        case (state)
            ST_RESET: upc_next = '0;
            ST_RUN: begin
                case (uir.seq_op)
                    SEQ_NEXT:     upc_next = upc_inc;
                    SEQ_JUMP:     upc_next = target_addr;
                    SEQ_BRANCH:   upc_next = cond_true ? target_addr : upc_inc;
                    SEQ_DISPATCH: upc_next = dispatch_addr;
                    SEQ_WAITMEM:  upc_next = mem_ready ? upc_inc : upc;
                    SEQ_HALT:     upc_next = upc;
                    default:      upc_next = upc_inc;
                endcase
            end
            default: upc_next = upc;
        endcase
    end

    // Control outputs: NOP outside RUN. While a memory wait is pending the
    // word keeps requesting the transfer but must not commit any register
    // write, since it will be executed again.
    always_comb begin
        lbus_selector            = LBUS_NOP;
        rbus_selector            = RBUS_NOP;
        alu_operation            = ALU_NOP;
        shifter_operation        = SHIFT_NOP;
        gpr_destination_selector = GPR_NOP;
        ir_source_selector       = IR_NOP;
        set_mar                  = 1'b0;
        set_fsr                  = 1'b0;
        set_pc                   = 1'b0;
        literal                  = '0;
        flags                    = '0;
        cin                      = 1'b0;
        inbus_valid              = 1'b0;
        if (running) begin
            lbus_selector            = uir.lbus_sel;
            rbus_selector            = uir.rbus_sel;
            alu_operation            = uir.alu_op;
            shifter_operation        = uir.shifter_op;
            gpr_destination_selector = uir.gpr_dest;
            ir_source_selector       = uir.ir_src;
            set_mar                  = uir.set_mar;
            set_fsr                  = uir.set_fsr;
            set_pc                   = uir.set_pc;
            literal                  = uir.literal;
            flags                    = uir.flags;
            cin                      = uir.cin;
            inbus_valid              = uir.mem_read;
            if (mem_stall) begin
                set_mar                  = 1'b0;
                set_fsr                  = 1'b0;
                set_pc                   = 1'b0;
                gpr_destination_selector = GPR_NOP;
            end
        end
    end

    assign ctrl.lbus_selector            = lbus_selector;
    assign ctrl.rbus_selector            = rbus_selector;
    assign ctrl.alu_operation            = alu_operation;
    assign ctrl.shifter_operation        = shifter_operation;
    assign ctrl.gpr_destination_selector = gpr_destination_selector;
    assign ctrl.ir_source_selector       = ir_source_selector;
    assign ctrl.set_mar                  = set_mar;
    assign ctrl.set_fsr                  = set_fsr;
    assign ctrl.set_pc                   = set_pc;
    assign ctrl.literal                  = literal;
    assign ctrl.flags                    = flags;
    assign ctrl.cin                      = cin;
    assign ctrl.inbus_valid              = inbus_valid;

    // Sequencer FSM. RESET lasts one cycle while the ROM fetches address 0;
    // HALT is left only through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RESET;
            upc    <= '0;
            halted <= 1'b0;
        end else begin
            upc <= upc_next;
            case (state)
                ST_RESET: state <= ST_RUN;
                ST_RUN: begin
                    if (uir.seq_op == SEQ_HALT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: doc/micro1_sequencer.md
# micro1_sequencer

Microprogram sequencer for the MICRO-1 core: the controller end of `control_interface`. Fetches one microinstruction per cycle from an external synchronous control-store ROM, drives every `controler` modport output from it, and computes the next micro-address from datapath status (carries, bus MSBs, IR dispatch). Sits between the control-store ROM and the datapath, which owns the `datapath` modport.

## Interface
- `CS_ADDR_WIDTH`, 10: control-store address width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `ctrl`  modport  `control_interface.controler`  datapath control and status bundle.
- `cs_addr`  out  `CS_ADDR_WIDTH`  control-store read address; combinational, equals `upc_next`.
- `cs_data`  in  `MICROINSTRUCTION`  ROM output for the address presented in the previous cycle.
- `mem_ready`  in  1  main-memory transfer complete.
- `halted`  out  1  sequencer stopped.

## Operation
- State machine `SEQ_STATE`: RESET, RUN, HALT. `rst_n=0` at an edge → RESET and `upc=0`, from any state, including mid-wait.
- RESET: lasts exactly one cycle while ROM loads address 0. All outputs are NOP, `cs_addr=0`. Next state is RUN.
- NOP output set: every selector and operation enum at encoding 0, which is its no-operation value. `set_mar`, `set_fsr`, `set_pc`, `cin` and `inbus_valid` are 0. `literal` and `flags` are 0.
- RUN: `uir = cs_data`. Outputs come combinationally from `uir` fields: lbus, rbus, alu, shifter, gpr_dest, ir_src, set_mar, set_fsr, set_pc, literal, flags, cin, mem_read→`inbus_valid`.
- `seq_op` (3 bits) selects `upc_next`:
  - NEXT: `upc+1`.
  - JUMP: `target`.
  - BRANCH: `target` if the condition holds, else `upc+1`.
  - DISPATCH: `{target[CS_ADDR_WIDTH-1:8], ir[15:8]}`.
  - WAITMEM: see below.
  - HALT: enter HALT.
  - Codes 6–7: treated as NEXT.
- `cond_sel` (3 bits) selects the condition: 0 `alu_cout`, 1 `shifter_cout`, 2 `lbus_msb`, 3 `rbus_msb`, 4 `sbus_msb`, 5 `abus==0`, 6 `rbus_lower==0`, 7 constant 1. `cond_invert` XORs the result.
- WAITMEM with `mem_ready=0`:
  - `upc_next=upc`, so the same word is re-read.
  - `inbus_valid` follows `uir`.
  - `set_mar`, `set_fsr`, `set_pc` are forced to 0, and `gpr_destination_selector` to NOP.
- WAITMEM with `mem_ready=1`: full outputs for that cycle, then `upc+1`.
- HALT: NOP outputs, `halted=1`, `cs_addr=upc` held. Left only by reset.
- Address arithmetic is modulo 2^`CS_ADDR_WIDTH`: `upc+1` at the top address wraps to 0.

## Timing
- One microinstruction per cycle in RUN; WAITMEM adds one cycle per `mem_ready=0` cycle.
- ROM latency is one cycle. `cs_addr` in cycle n determines `cs_data` in cycle n+1.
- Status inputs are sampled in the same cycle as the microinstruction that produces them. There is no combinational loop, because the ROM output is registered.
- Reset values: `upc=0`, state RESET, `halted=0`, all `ctrl` outputs NOP, `cs_addr=0`.
- BRANCH, DISPATCH and JUMP have zero penalty: the target executes in the next cycle.
- The `halted` rise is registered: 1 the cycle after the HALT word executes.

## Structure
- New package `package_micro_sequencer` holds:
  - `MICROINSTRUCTION` packed struct: selector and operation fields typed with the existing package enums, plus `literal`, `flags`, `cin`, `mem_read`, `seq_op`, `cond_sel`, `cond_invert`, `target`.
  - `SEQ_OPERATION` and `CONDITION_SELECT` enums.
  - `SEQ_STATE` enum.
- Sub-module `micro1_condition_mux`: combinational 8:1 condition select plus invert.
- The top module holds the FSM, `upc` and the next-address logic.

## Test plan
- Reset then NEXT words at 0,1,2: `cs_addr` sequence 0,1,2,3 with `ctrl` matching each word. Asserting `rst_n=0` mid-stream gives `cs_addr=0` and NOP outputs the next cycle.
- BRANCH `cond_sel=0`, target 0x40, at upc 5:
  - `alu_cout=1` → 0x40.
  - `alu_cout=0` → 6.
  - `cond_invert=1` with `alu_cout=0` → 0x40.
- DISPATCH with `target=0x300`, `ir=0xA5xx` → `upc_next=0x3A5`.
- WAITMEM with `set_mar=1` and `mem_ready` low for 3 cycles:
  - `set_mar=0` and `inbus_valid=1` for 3 cycles, with `cs_addr` held.
  - On the 4th cycle `set_mar=1`, then upc+1.
- NEXT at address 0x3FF → `cs_addr=0`.
- HALT word → `halted=1` the next cycle, outputs NOP and `cs_addr` frozen for 10 cycles. `rst_n=0` clears `halted` and restarts at 0.
